ram_moc_ctrl: RTL and testbench

RAM_MOC_CTRL -- requirements
Module: ram_moc_ctrl

---
 rtl/ram_moc_ctrl.sv | 126 ++++++++++++
 tb/tb_ram_moc_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ram_moc_ctrl.sv
// Byte-addressed big-endian RAM behind a mfa/moc handshake.
// Accesses pass through optional wait states, then one access cycle, then complete.
module ram_moc_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mfa,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  input  logic [2:0]        wait_cfg,
  output logic [31:0]       data_out,
  output logic              moc,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  localparam logic [2:0] MAXW = 3'(MAX_WAIT);

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic [31:0]       dout_q;
  logic              moc_q, err_q;

  logic [7:0]        mem [2**ADDR_W];

  logic [2:0]        wcfg;
  logic              bad;
  logic [ADDR_W-1:0] a1, a2, a3;
  logic [31:0]       rdata;

  assign wcfg = (wait_cfg > MAXW) ? MAXW : wait_cfg;
  assign a1   = addr_q + ADDR_W'(1);
  assign a2   = addr_q + ADDR_W'(2);
  assign a3   = addr_q + ADDR_W'(3);

  assign bad = (size_q == 2'b11) ||
               (size_q == 2'b01 && addr_q[0]) ||
               (size_q == 2'b10 && addr_q[1:0] != 2'b00);

  // Big-endian gather: lowest address lands in the most significant selected byte.
  always_comb begin
    rdata = '0;
    case (size_q)
      2'b00:   rdata[7:0]  = mem[addr_q];
      2'b01:   rdata[15:0] = {mem[addr_q], mem[a1]};
      2'b10:   rdata       = {mem[addr_q], mem[a1], mem[a2], mem[a3]};
      default: rdata       = '0;
    endcase
  end

  // Memory is never reset; only a legal write that reaches ACCESS touches it.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ACCESS && !rw_q && !bad) begin
      case (size_q)
        2'b00: mem[addr_q] <= wdata_q[7:0];
        2'b01: begin
          mem[addr_q] <= wdata_q[15:8];
          mem[a1]     <= wdata_q[7:0];
        end
        2'b10: begin
          mem[addr_q] <= wdata_q[31:24];
          mem[a1]     <= wdata_q[23:16];
          mem[a2]     <= wdata_q[15:8];
          mem[a3]     <= wdata_q[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (mfa) begin
          addr_q  <= address;
          rw_q    <= rw;
          size_q  <= size;
          wdata_q <= data_in;
          cnt_q   <= wcfg;
          state_q <= (wcfg != 3'd0) ? WAIT : ACCESS;
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_q <= ACCESS;
        end
        ACCESS: begin
          moc_q   <= 1'b1;
          err_q   <= bad;
          state_q <= DONE;
          if (bad)       dout_q <= '0;
          else if (rw_q) dout_q <= rdata;
        end
        DONE: if (!mfa) begin
          moc_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out = dout_q;
  assign moc      = moc_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ram_moc_ctrl.sv
// Directed bench for ram_moc_ctrl: handshake latency, big-endian layout,
// alignment rejection, DONE hold, and asynchronous reset abort.
module tb_ram_moc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mfa, rw;
  logic [1:0]  size;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic [2:0]  wait_cfg;
  logic [31:0] data_out;
  logic        moc, err;

  int nvec = 0;
  int nerr = 0;

  ram_moc_ctrl #(.ADDR_W(8), .MAX_WAIT(7)) dut (
    .clk(clk), .reset(reset), .mfa(mfa), .rw(rw), .size(size),
    .address(address), .data_in(data_in), .wait_cfg(wait_cfg),
    .data_out(data_out), .moc(moc), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch a request just after an edge; the controller samples it on the next
  // edge, so completion is expected wc+2 edges after the launching edge.
  // Inputs are scrambled once sampled to prove only latched copies are used.
  task automatic req(input string tag, input logic r, input logic [1:0] sz,
                     input logic [7:0] a, input logic [31:0] d, input logic [2:0] wc,
                     input logic [31:0] exp_do, input logic exp_err);
    int lat;
    rw = r; size = sz; address = a; data_in = d; wait_cfg = wc; mfa = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        rw = ~r; size = ~sz; address = ~a; data_in = ~d; wait_cfg = ~wc;
      end
    end while (!moc && lat < 40);
    chk({tag, " latency"}, 32'(lat), 32'(wc) + 32'd2);
    chk({tag, " moc"}, 32'(moc), 32'd1);
    chk({tag, " data_out"}, data_out, exp_do);
    chk({tag, " err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic rel(input string tag);
    mfa = 1'b0;
    @(posedge clk); #1;
    chk({tag, " moc drop"}, 32'(moc), 32'd0);
    chk({tag, " err drop"}, 32'(err), 32'd0);
  endtask

  initial begin
    reset = 1'b1; mfa = 1'b0; rw = 1'b0; size = 2'b00;
    address = '0; data_in = '0; wait_cfg = '0;
    #2;
    chk("reset moc", 32'(moc), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset data_out", data_out, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Word write then byte/halfword reads of the big-endian layout
    req("wr DEADBEEF@10", 1'b0, 2'b10, 8'h10, 32'hDEADBEEF, 3'd0, 32'h0, 1'b0);
    rel("wr DEADBEEF@10");
    req("rdb @10", 1'b1, 2'b00, 8'h10, 32'h0, 3'd0, 32'h000000DE, 1'b0);
    rel("rdb @10");
    req("rdb @13", 1'b1, 2'b00, 8'h13, 32'h0, 3'd0, 32'h000000EF, 1'b0);
    rel("rdb @13");
    req("rdh @12", 1'b1, 2'b01, 8'h12, 32'h0, 3'd2, 32'h0000BEEF, 1'b0);
    rel("rdh @12");
    req("rdw @10 wc5", 1'b1, 2'b10, 8'h10, 32'h0, 3'd5, 32'hDEADBEEF, 1'b0);
    rel("rdw @10 wc5");

    // Misaligned halfword write must be rejected and leave memory alone
    req("wr 01020304@20", 1'b0, 2'b10, 8'h20, 32'h01020304, 3'd2, 32'hDEADBEEF, 1'b0);
    rel("wr 01020304@20");
    req("wrh misaligned @21", 1'b0, 2'b01, 8'h21, 32'h00001234, 3'd0, 32'h0, 1'b1);
    rel("wrh misaligned @21");
    req("rdw @20", 1'b1, 2'b10, 8'h20, 32'h0, 3'd3, 32'h01020304, 1'b0);
    rel("rdw @20");
    req("rd size11 @20", 1'b1, 2'b11, 8'h20, 32'h0, 3'd0, 32'h0, 1'b1);
    rel("rd size11 @20");

    // Hold mfa in DONE, then back-to-back request right after leaving DONE
    req("rdw @10 hold", 1'b1, 2'b10, 8'h10, 32'h0, 3'd1, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("hold moc", 32'(moc), 32'd1);
      chk("hold data_out", data_out, 32'hDEADBEEF);
    end
    rel("rdw @10 hold");
    req("rdb @11 back2back", 1'b1, 2'b00, 8'h11, 32'h0, 3'd0, 32'h000000AD, 1'b0);
    rel("rdb @11 back2back");

    // Reset during WAIT abandons the write
    req("wr 55667788@30", 1'b0, 2'b10, 8'h30, 32'h55667788, 3'd0, 32'h000000AD, 1'b0);
    rel("wr 55667788@30");
    rw = 1'b0; size = 2'b10; address = 8'h30; data_in = 32'hCAFEF00D;
    wait_cfg = 3'd4; mfa = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort moc", 32'(moc), 32'd0);
    chk("abort data_out", data_out, 32'd0);
    mfa = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    req("rdw @30 after abort", 1'b1, 2'b10, 8'h30, 32'h0, 3'd0, 32'h55667788, 1'b0);

    // Reset while holding DONE clears outputs without waiting for an edge
    #3 reset = 1'b1;
    #1;
    chk("done reset moc", 32'(moc), 32'd0);
    chk("done reset data_out", data_out, 32'd0);
    mfa = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    // Byte write merges into an existing word
    req("wr 11223344@40", 1'b0, 2'b10, 8'h40, 32'h11223344, 3'd0, 32'h0, 1'b0);
    rel("wr 11223344@40");
    req("wrb AB@42", 1'b0, 2'b00, 8'h42, 32'hFFFFFFAB, 3'd7, 32'h0, 1'b0);
    rel("wrb AB@42");
    req("rdw @40 merged", 1'b1, 2'b10, 8'h40, 32'h0, 3'd0, 32'h1122AB44, 1'b0);
    rel("rdw @40 merged");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
